// File: rtl/rv32_mem_pkg.sv
// Shared MEM-stage definitions: funct3 codes, sequencer states, latched request and lane helpers.
// Pure declarations and functions; no timing or flow control of its own.
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD} memst_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    // Unknown funct3 encodings fall through to word size for both loads and stores.
    function automatic size_t access_size(input logic [2:0] f3, input logic we);
        if (f3 == F3_SB || (!we && f3 == F3_LBU))
            return SZ_B;
        if (f3 == F3_SH || (!we && f3 == F3_LHU))
            return SZ_H;
        return SZ_W;
    endfunction

    function automatic logic [3:0] lane_mask(input size_t sz, input logic [1:0] a);
        case (sz)
            SZ_B:    return 4'b0001 << a;
            SZ_H:    return 4'b0011 << {a[1], 1'b0};
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input size_t sz, input logic [31:0] d);
        case (sz)
            SZ_B:    return {4{d[7:0]}};
            SZ_H:    return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] a);
        case (sz)
            SZ_H:    return a[0];
            SZ_W:    return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load lane select and sign/zero extension of the returned bus word.
// Purely combinational; no flow control.
import rv32_mem_pkg::*;

module load_align (
    input  logic [31:0] drdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = drdata[7:0];
            2'd1:    byte_sel = drdata[15:8];
            2'd2:    byte_sel = drdata[23:16];
            default: byte_sel = drdata[31:24];
        endcase
        half_sel = addr[1] ? drdata[31:16] : drdata[15:0];

        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  load_data = {24'b0, byte_sel};
            F3_LHU:  load_data = {16'b0, half_sel};
            default: load_data = drdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-bus sequencer: stores complete in the grant cycle, loads stall until rvalid (>=1 cycle).
// Holds stall while waiting for dgnt/drvalid. Optional trap on misaligned access: MEM_MISALIGN_TRAP_EN.
import rv32_mem_pkg::*;

module mem_access_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [2:0]             funct3,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic                   dreq,
    output logic                   dwe,
    output logic [31:0]            daddr,
    output logic [3:0]             dbe,
    output logic [31:0]            dwdata,
    input  logic                   dgnt,
    input  logic                   drvalid,
    input  logic [31:0]            drdata,
    output logic                   stall,
    output logic [31:0]            load_data,
    output logic                   misalign,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    memst_t   state, nxt;
    mem_req_t lat, cur, bus_req;
    size_t    bus_sz;
    logic     access, is_store, trap, issue;
    logic [31:0] aligned;

    assign access   = (mem_read | mem_write) & ~reset;
    assign is_store = mem_write & ~mem_read;
    assign cur      = '{we: is_store, funct3: funct3, addr: addr, wdata: wdata};

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = access & misaligned(access_size(funct3, is_store), addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign misalign = (state == IDLE) & trap;
    assign issue    = (state == IDLE) & access & ~trap;

    // First request cycle drives the bus straight from EX/MEM; retries use the latched copy.
    assign bus_req = (state == IDLE) ? cur : lat;
    assign bus_sz  = access_size(bus_req.funct3, bus_req.we);
    assign daddr   = {bus_req.addr[31:2], 2'b00};
    assign dbe     = lane_mask(bus_sz, bus_req.addr[1:0]);
    assign dwdata  = lane_data(bus_sz, bus_req.wdata);
    assign dwe     = dreq & bus_req.we;

    always_comb begin
        nxt   = state;
        dreq  = 1'b0;
        stall = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    dreq = 1'b1;
                    if (!dgnt) begin
                        nxt   = REQ;
                        stall = 1'b1;
                    end else if (!is_store) begin
                        nxt   = WAIT_RD;
                        stall = 1'b1;
                    end
                end
            end
            REQ: begin
                dreq = 1'b1;
                if (!dgnt) begin
                    stall = 1'b1;
                end else if (lat.we) begin
                    nxt = IDLE;
                end else begin
                    nxt   = WAIT_RD;
                    stall = 1'b1;
                end
            end
            WAIT_RD: begin
                if (drvalid) nxt = IDLE;
                else         stall = 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

    load_align u_load_align (
        .drdata    (drdata),
        .addr      (lat.addr[1:0]),
        .funct3    (lat.funct3),
        .load_data (aligned)
    );

    assign load_data = (state == WAIT_RD && drvalid) ? aligned : 32'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            lat          <= '0;
            stall_cycles <= '0;
        end else begin
            state <= nxt;
            if (issue)
                lat <= cur;
            if (stall && stall_cycles != {STALL_CNT_W{1'b1}})
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
